// File: rtl/gol_sequencer.sv
// Sequencer for the Game of Life engine and its double-buffered framebuffer.
// It seeds the grid from an LFSR, paces generations to display frames and swaps buffers only on frame start.
module gol_sequencer #(
    parameter int          WIDTH         = 480,
    parameter int          HEIGHT        = 272,
    parameter int          GEN_DIV       = 4,
    parameter logic [15:0] LFSR_INIT     = 16'hACE1,
    parameter bit          SEED_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        run,
    input  logic        step,
    input  logic        seed_req,
    output logic        gol_start,
    input  logic        gol_done,
    input  logic [16:0] gol_addr,
    input  logic        gol_dout,
    input  logic        gol_write,
    output logic [16:0] fb_addra,
    output logic        fb_din,
    output logic        fb_wrea,
    output logic        ab,
    output logic        busy,
    output logic [15:0] gen_count
);

    localparam logic [16:0] LAST_ADDR  = 17'(WIDTH * HEIGHT - 1);
    localparam logic [7:0]  LAST_FRAME = 8'(GEN_DIV - 1);

    typedef enum logic [1:0] {
        ST_SEED,
        ST_WAIT_GEN,
        ST_GEN,
        ST_SWAP_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        ab_q, ab_d;
    logic        gol_start_q, gol_start_d;
    logic [15:0] gen_count_q, gen_count_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [16:0] seed_addr_q, seed_addr_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        seed_pend_q, seed_pend_d;
    logic        step_pend_q, step_pend_d;
    logic        lfsr_fb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (SEED_ON_RESET) begin
                state_q <= ST_SEED;
            end else begin
                state_q <= ST_WAIT_GEN;
            end
            ab_q        <= 1'b0;
            gol_start_q <= 1'b0;
            gen_count_q <= 16'd0;
            frame_cnt_q <= 8'd0;
            seed_addr_q <= 17'd0;
            lfsr_q      <= LFSR_INIT;
            seed_pend_q <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ab_q        <= ab_d;
            gol_start_q <= gol_start_d;
            gen_count_q <= gen_count_d;
            frame_cnt_q <= frame_cnt_d;
            seed_addr_q <= seed_addr_d;
            lfsr_q      <= lfsr_d;
            seed_pend_q <= seed_pend_d;
            step_pend_q <= step_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ab_d        = ab_q;
        gol_start_d = 1'b0;
        gen_count_d = gen_count_q;
        frame_cnt_d = frame_cnt_q;
        seed_addr_d = seed_addr_q;
        lfsr_d      = lfsr_q;
        seed_pend_d = seed_pend_q;
        step_pend_d = step_pend_q;
        lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

        case (state_q)
            ST_SEED: begin
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                if (seed_addr_q == LAST_ADDR) begin
                    seed_addr_d = 17'd0;
                    state_d     = ST_SWAP_WAIT;
                end else begin
                    seed_addr_d = seed_addr_q + 17'd1;
                end
            end
            ST_WAIT_GEN: begin
                // A reseed wins over launching a generation in the same cycle.
                if (seed_pend_q || seed_req) begin
                    seed_pend_d = 1'b0;
                    state_d     = ST_SEED;
                end else if (run) begin
                    if (frame_start) begin
                        if (frame_cnt_q == LAST_FRAME) begin
                            frame_cnt_d = 8'd0;
                            gol_start_d = 1'b1;
                            state_d     = ST_GEN;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    frame_cnt_d = 8'd0;
                    if (step || step_pend_q) begin
                        step_pend_d = 1'b0;
                        gol_start_d = 1'b1;
                        state_d     = ST_GEN;
                    end
                end
            end
            ST_GEN: begin
                if (gol_done) begin
                    gen_count_d = gen_count_q + 16'd1;
                    state_d     = ST_SWAP_WAIT;
                end
            end
            ST_SWAP_WAIT: begin
                // Entered after the done cycle, so a coincident frame_start never swaps early.
                if (frame_start) begin
                    ab_d    = ~ab_q;
                    state_d = ST_WAIT_GEN;
                end
            end
            default: begin
                state_d = ST_WAIT_GEN;
            end
        endcase

        if (state_q == ST_GEN || state_q == ST_SWAP_WAIT) begin
            if (seed_req) begin
                seed_pend_d = 1'b1;
            end
            if (step && !run) begin
                step_pend_d = 1'b1;
            end
        end
    end

    always_comb begin
        if (state_q == ST_SEED) begin
            fb_addra = seed_addr_q;
            fb_din   = lfsr_q[0] & lfsr_q[1];
            fb_wrea  = 1'b1;
        end else begin
            fb_addra = gol_addr;
            fb_din   = gol_dout;
            fb_wrea  = gol_write;
        end
    end

    assign gol_start = gol_start_q;
    assign ab        = ab_q;
    assign busy      = (state_q == ST_SEED) || (state_q == ST_GEN);
    assign gen_count = gen_count_q;

endmodule
